// File: rtl/beep_pattern_gen_pkg.sv
// Shared user-interface constants for the parcel-locker front panel.
// All 50 MHz-derived timings and the buzzer FSM encoding live here.
package beep_pattern_gen_pkg;

    localparam int TONE_HALF_1KHZ = 25_000;
    localparam int BEEP_100MS     = 5_000_000;
    localparam int DEBOUNCE_20MS  = 1_000_000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ON   = ST_ON,
        OFF  = ST_OFF
    } beep_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/beep_pattern_gen_tone_div.sv
// Square-wave tone divider: half-period counter plus toggle flop holding the pin level.
// load restarts the tone at its audible phase; with neither load nor en the pin is held silent.
module beep_pattern_gen_tone_div
    import beep_pattern_gen_pkg::*;
#(
    parameter int HALF   = TONE_HALF_1KHZ,
    parameter bit INVERT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    output logic wave
);

    localparam int         W    = cnt_width(HALF);
    localparam logic [W-1:0] LAST = W'(HALF - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            wave <= INVERT;
        end else if (load) begin
            cnt  <= '0;
            wave <= ~INVERT;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                wave <= ~wave;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt  <= '0;
            wave <= INVERT;
        end
    end

endmodule

// File: rtl/beep_pattern_gen.sv
// Buzzer burst generator: plays beep_count tone beeps separated by silence, with abort.
// state | meaning
// IDLE  | silent, waiting for start
// ON    | tone active for ON_TIME cycles
// OFF   | silent gap of OFF_TIME cycles between beeps
module beep_pattern_gen
    import beep_pattern_gen_pkg::*;
#(
    parameter int TONE_HALF  = TONE_HALF_1KHZ,
    parameter int ON_TIME    = BEEP_100MS,
    parameter int OFF_TIME   = BEEP_100MS,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] beep_count,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       buzzer_out
);

    localparam int DUR_MAX = (ON_TIME > OFF_TIME) ? ON_TIME : OFF_TIME;
    localparam int DUR_W   = cnt_width(DUR_MAX);
    localparam logic [DUR_W-1:0] ON_LAST  = DUR_W'(ON_TIME - 1);
    localparam logic [DUR_W-1:0] OFF_LAST = DUR_W'(OFF_TIME - 1);

    beep_state_t      state, state_nxt;
    logic [DUR_W-1:0] dur_cnt, dur_nxt;
    logic [3:0]       remaining, rem_nxt;
    logic             busy_nxt, done_nxt;
    logic             tone_en, tone_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dur_cnt   <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            dur_cnt   <= dur_nxt;
            remaining <= rem_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dur_nxt   = dur_cnt;
        rem_nxt   = remaining;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                // start beats a simultaneous abort; abort alone does nothing here
                if (start) begin
                    if (beep_count != 4'd0) begin
                        state_nxt = ON;
                        rem_nxt   = beep_count;
                        dur_nxt   = '0;
                        busy_nxt  = 1'b1;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ON: begin
                if (abort) begin
                    state_nxt = IDLE;
                    dur_nxt   = '0;
                    rem_nxt   = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else if (dur_cnt == ON_LAST) begin
                    rem_nxt = remaining - 4'd1;
                    dur_nxt = '0;
                    if (remaining > 4'd1) begin
                        state_nxt = OFF;
                    end else begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    dur_nxt = dur_cnt + 1'b1;
                end
            end
            OFF: begin
                if (abort) begin
                    state_nxt = IDLE;
                    dur_nxt   = '0;
                    rem_nxt   = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else if (dur_cnt == OFF_LAST) begin
                    state_nxt = ON;
                    dur_nxt   = '0;
                end else begin
                    dur_nxt = dur_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                dur_nxt   = '0;
                rem_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Tone restarts on every entry to ON and keeps running only while ON persists.
    always_comb begin
        tone_load = (state_nxt == ON) && (state != ON);
        tone_en   = (state_nxt == ON) && (state == ON);
    end

    beep_pattern_gen_tone_div #(
        .HALF   (TONE_HALF),
        .INVERT (ACTIVE_LOW)
    ) u_tone_div (
        .clk  (clk),
        .rst  (rst),
        .en   (tone_en),
        .load (tone_load),
        .wave (buzzer_out)
    );

endmodule

// File: doc/beep_pattern_gen.md
Name: beep_pattern_gen

Overview:
- Drives the parcel-locker buzzer output pin with a burst of N tone beeps on request.
- Provides audible feedback for keypad presses, code accept and code reject.
- Sits on the output side of the user interface. Debounced key events are the input path; this block is the feedback path back to the user.
- Controller logic requests a burst with a one-cycle start pulse and a beep count, and receives busy/done status.

Parameters:
- TONE_HALF, 25_000: clk cycles per half tone period (1 kHz at 50 MHz).
- ON_TIME, 5_000_000: clk cycles per beep, tone active (100 ms).
- OFF_TIME, 5_000_000: clk cycles of silence between beeps (100 ms).
- ACTIVE_LOW, 0: if 1, invert buzzer_out at the pin (idle level becomes 1).

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request pulse
- beep_count  in  4  beeps requested (0..15), sampled with start
- abort  in  1  level; silences and terminates the current burst
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at burst completion or abort
- buzzer_out  out  1  registered buzzer drive

Behaviour:
- Single clock domain; one clock; reset is asynchronous and active-high.
- All outputs registered.
- Reset values: busy=0, done=0, buzzer_out=ACTIVE_LOW (silent), state=IDLE, all counters 0.
- FSM states: IDLE, ON, OFF.
- IDLE:
  - start=1 with beep_count>0: latch remaining=beep_count, go ON next cycle, busy=1, tone phase=1, tone_cnt=0, dur_cnt=0.
  - start=1 with beep_count=0: stay IDLE, pulse done the next cycle, busy stays 0.
- ON:
  - tone_cnt counts 0..TONE_HALF-1; at TONE_HALF-1 the tone phase toggles and tone_cnt wraps to 0.
  - buzzer_out = tone phase XOR ACTIVE_LOW.
  - dur_cnt counts 0..ON_TIME-1. At ON_TIME-1, decrement remaining:
    - if remaining was >1, go OFF with dur_cnt=0;
    - otherwise go IDLE, done=1 for one cycle, busy=0 in the same cycle.
- OFF:
  - buzzer_out silent.
  - dur_cnt counts 0..OFF_TIME-1; at OFF_TIME-1, go ON with tone phase=1, tone_cnt=0, dur_cnt=0.
- Latency:
  - start to first audible edge: 1 cycle.
  - Total busy duration for N beeps: N*ON_TIME + (N-1)*OFF_TIME cycles.
- start while busy: ignored. No queueing; remaining is not reloaded.
- abort:
  - Priority over all transitions.
  - In ON or OFF: next cycle state=IDLE, buzzer silent, busy=0, done=1 (one cycle).
  - In IDLE: no effect and no done.
  - If abort and start arrive in the same IDLE cycle, start wins.
- Counter widths: $clog2 of the respective parameter, minimum 1. Counters never wrap past their terminal value.
- Reset mid-burst: immediate silence, all state cleared, no done pulse.
- done never asserts together with busy=1 on the same cycle.

Decomposition:
- Shared UI package holds:
  - state encoding localparams (IDLE=2'd0, ON=2'd1, OFF=2'd2);
  - default timing constants (TONE_HALF_1KHZ, BEEP_100MS) alongside the existing 20 ms debounce constant, so all 50 MHz-derived timings live in one place.
- One natural sub-module: tone_div. Counter plus toggle flip-flop with enable and synchronous phase reload; produces the square wave. The FSM and duration counter stay in the top module.

Test Plan (sim with TONE_HALF=2, ON_TIME=8, OFF_TIME=4, ACTIVE_LOW=0):
- Reset values: assert rst mid-simulation → buzzer_out=0, busy=0, done=0 asynchronously, before the next clk edge.
- Two beeps: start pulse, beep_count=2 →
  - busy high for 20 cycles;
  - buzzer_out pattern 1,1,0,0,1,1,0,0 twice, separated by 4 zero cycles;
  - done pulses once, busy low on that cycle.
- Zero count: start with beep_count=0 → done pulses the next cycle, busy stays 0, buzzer_out stays 0.
- Start while busy: beep_count=1, then start with beep_count=5 at cycle 3 → burst still ends after 8 cycles, single done.
- Abort: beep_count=3, abort at cycle 10 (during OFF) → next cycle busy=0, done=1, buzzer_out=0. A later start is accepted normally.
- Inverted pin: ACTIVE_LOW=1, beep_count=1 → idle level 1, pattern 0,0,1,1,0,0,1,1, returns to 1 after done.
